// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the word-level run-of-ones detector controller.
// The count width is derived from the word width so every possible count fits.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_e;

   localparam int DEF_WORD_W  = 10;
   localparam int DEF_RUN_LEN = 3;

   function automatic int calc_cnt_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/run_detector.sv
// Serial run-of-ones detector: z is high on a 1 that follows at least RUN_LEN-1 ones.
// One bit per enabled cycle; the run counter saturates at RUN_LEN-1 and clr overrides en.
module run_detector #(
   parameter int RUN_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic bit_in,
   output logic z
);

   localparam int RUN_W = $clog2(RUN_LEN);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN - 1);

   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;

   assign z = bit_in && (run_q >= RUN_MAX);

   always_comb begin
      run_d = run_q;
      if (clr) begin
         run_d = '0;
      end else if (en) begin
         if (!bit_in) begin
            run_d = '0;
         end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/seq_det_word_ctrl.sv
// Accepts a word, shifts it MSB-first through run_detector, reports mask/count WORD_W cycles later.
// REPORT holds until out_ready; no new word is taken while a result is pending.
module seq_det_word_ctrl
   import seq_det_pkg::*;
#(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int RUN_LEN = DEF_RUN_LEN,
   parameter int CNT_W   = calc_cnt_w(WORD_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              carry_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_mask,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy
);

   localparam int IDX_W = $clog2(WORD_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  mask_q, mask_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic det_en;
   logic det_clr;
   logic det_bit;
   logic det_z;

   assign det_bit = word_q[idx_q];

   run_detector #(
      .RUN_LEN (RUN_LEN)
   ) u_run_detector (
      .clk    (clk),
      .rst    (rst),
      .en     (det_en),
      .clr    (det_clr),
      .bit_in (det_bit),
      .z      (det_z)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      count_d = count_q;
      det_en  = 1'b0;
      det_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_word;
               idx_d   = IDX_TOP;
               mask_d  = '0;
               count_d = '0;
               // Without carry the new word must not see runs from the previous one.
               det_clr = !carry_en;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            det_en        = 1'b1;
            mask_d[idx_q] = det_z;
            count_d       = count_q + CNT_W'(det_z);
            if (idx_q == '0) begin
               state_d = REPORT;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         REPORT: begin
            // Run history stays in the detector for a possible carry into the next word.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == REPORT);
   assign busy      = (state_q != IDLE);
   assign out_mask  = mask_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_seq_det_word_ctrl.sv
// Bench for seq_det_word_ctrl: directed scenarios plus random words against a streak-length model.
module tb_seq_det_word_ctrl;

   localparam int WORD_W  = 10;
   localparam int RUN_LEN = 3;
   localparam int CNT_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic              carry_en;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_mask;
   logic [CNT_W-1:0]  out_count;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   // Reference: length of the current streak of ones across the bit stream, unbounded.
   int                model_streak = 0;
   logic [WORD_W-1:0] exp_mask;
   logic [CNT_W-1:0]  exp_count;

   always #5 clk = ~clk;

   seq_det_word_ctrl #(
      .WORD_W  (WORD_W),
      .RUN_LEN (RUN_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .carry_en  (carry_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_count (out_count),
      .busy      (busy)
   );

   task automatic model_word(input logic [WORD_W-1:0] w, input bit c);
      if (!c) model_streak = 0;
      exp_mask  = '0;
      exp_count = '0;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (w[i]) begin
            model_streak++;
            if (model_streak >= RUN_LEN) begin
               exp_mask[i] = 1'b1;
               exp_count   = exp_count + 1'b1;
            end
         end else begin
            model_streak = 0;
         end
      end
   endtask

   // Offers a word from a falling edge, returns at the falling edge after acceptance.
   task automatic accept(input logic [WORD_W-1:0] w, input bit c);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      carry_en = c;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_timeout in_ready=%0b want=1", in_ready);
      end
      @(posedge clk);
      model_word(w, c);
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = WORD_W'($urandom);
      carry_en = 1'($urandom);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL result_timeout out_valid=%0b want=1", out_valid);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_mask !== '0 || out_count !== '0) begin
         failures++;
         $display("FAIL reset_during rdy/vld/busy=%b mask=%h cnt=%0d want 100/0/0",
                  {in_ready, out_valid, busy}, out_mask, out_count);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_mask !== '0 || out_count !== '0) begin
         failures++;
         $display("FAIL reset_after rdy/vld/busy=%b mask=%h cnt=%0d want 100/0/0",
                  {in_ready, out_valid, busy}, out_mask, out_count);
      end
   endtask

   task automatic test_all_ones();
      int lat;
      accept(10'b1111111111, 1'b0);
      wait_result(lat);
      checks++;
      if (lat != WORD_W) begin
         failures++;
         $display("FAIL all_ones_latency got=%0d want=%0d", lat, WORD_W);
      end
      checks++;
      if (out_mask !== 10'b0011111111 || out_count !== 4'd8) begin
         failures++;
         $display("FAIL all_ones mask=%b cnt=%0d want 0011111111/8", out_mask, out_count);
      end
      consume();
   endtask

   task automatic test_pattern();
      int lat;
      accept(10'b1101110111, 1'b0);
      wait_result(lat);
      checks++;
      if (out_mask !== 10'b0000010001 || out_count !== 4'd2) begin
         failures++;
         $display("FAIL pattern mask=%b cnt=%0d want 0000010001/2", out_mask, out_count);
      end
      consume();
   endtask

   task automatic test_carry();
      int lat;
      for (int k = 0; k < 2; k++) begin
         accept(10'b0000000011, 1'b0);
         wait_result(lat);
         consume();
         accept(10'b1000000000, (k == 0));
         wait_result(lat);
         checks++;
         if (k == 0 && (out_mask !== 10'b1000000000 || out_count !== 4'd1)) begin
            failures++;
            $display("FAIL carry_on mask=%b cnt=%0d want 1000000000/1", out_mask, out_count);
         end else if (k == 1 && (out_mask !== '0 || out_count !== '0)) begin
            failures++;
            $display("FAIL carry_off mask=%b cnt=%0d want 0/0", out_mask, out_count);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [WORD_W-1:0] held_mask;
      logic [CNT_W-1:0]  held_count;
      logic [WORD_W-1:0] nw;
      nw = 10'b0111011110;
      accept(10'b0011111100, 1'b0);
      wait_result(lat);
      held_mask  = exp_mask;
      held_count = exp_count;
      in_valid = 1'b1;
      in_word  = nw;
      carry_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== held_mask ||
             out_count !== held_count) begin
            failures++;
            $display("FAIL hold_%0d vld=%b rdy=%b mask=%b cnt=%0d want 1/0/%b/%0d",
                     i, out_valid, in_ready, out_mask, out_count, held_mask, held_count);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL after_handshake rdy=%b busy=%b vld=%b want 1/0/0", in_ready, busy, out_valid);
      end
      @(posedge clk);
      model_word(nw, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL late_accept busy=%b rdy=%b want 1/0", busy, in_ready);
      end
      wait_result(lat);
      checks++;
      if (lat != WORD_W || out_mask !== exp_mask || out_count !== exp_count) begin
         failures++;
         $display("FAIL late_word lat=%0d mask=%b cnt=%0d want %0d/%b/%0d",
                  lat, out_mask, out_count, WORD_W, exp_mask, exp_count);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int lat;
      accept(10'b1111111111, 1'b0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      model_streak = 0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid vld=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      accept(10'b1000000000, 1'b1);
      wait_result(lat);
      checks++;
      if (out_count !== 4'd0 || out_mask !== '0) begin
         failures++;
         $display("FAIL reset_history mask=%b cnt=%0d want 0/0", out_mask, out_count);
      end
      consume();
   endtask

   task automatic test_zero_busy();
      int busy_cycles = 0;
      logic seen = 1'b0;
      logic [WORD_W-1:0] m = '1;
      logic [CNT_W-1:0]  c = '1;
      out_ready = 1'b1;
      accept(10'b0000000000, 1'b0);
      while (busy && busy_cycles < 40) begin
         busy_cycles++;
         if (out_valid) begin
            seen = 1'b1;
            m    = out_mask;
            c    = out_count;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (busy_cycles != WORD_W + 1) begin
         failures++;
         $display("FAIL zero_busy_cycles got=%0d want=%0d", busy_cycles, WORD_W + 1);
      end
      checks++;
      if (seen !== 1'b1 || m !== '0 || c !== '0) begin
         failures++;
         $display("FAIL zero_result seen=%b mask=%b cnt=%0d want 1/0/0", seen, m, c);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int n = 0; n < 24; n++) begin
         accept(WORD_W'($urandom), 1'($urandom_range(0, 1)));
         wait_result(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         checks++;
         if (lat != WORD_W || out_valid !== 1'b1 || out_mask !== exp_mask ||
             out_count !== exp_count) begin
            failures++;
            $display("FAIL random_%0d lat=%0d vld=%b mask=%b cnt=%0d want %0d/1/%b/%0d",
                     n, lat, out_valid, out_mask, out_count, WORD_W, exp_mask, exp_count);
         end
         consume();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      carry_en  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_all_ones();
      test_pattern();
      test_carry();
      test_backpressure();
      test_reset_mid();
      test_zero_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
